// File: rtl/regbus_arbiter.sv
// regbus_arbiter: two-host round-robin arbiter and single-transaction
// sequencer for the 32-bit register/memory bus (ADDR/WE/RE/DATA_WR/WSTRB,
// DATA_RD/READY). Each granted transaction ends in a one-cycle done pulse
// carrying read data or a timeout error back to the winning host.
module regbus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            h0_req,
    input  logic            h0_we,
    input  logic [AW-1:0]   h0_addr,
    input  logic [DW-1:0]   h0_wdata,
    input  logic [DW/8-1:0] h0_wstrb,
    output logic            h0_done,
    output logic [DW-1:0]   h0_rdata,
    output logic            h0_err,
    input  logic            h1_req,
    input  logic            h1_we,
    input  logic [AW-1:0]   h1_addr,
    input  logic [DW-1:0]   h1_wdata,
    input  logic [DW/8-1:0] h1_wstrb,
    output logic            h1_done,
    output logic [DW-1:0]   h1_rdata,
    output logic            h1_err,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_wstrb,
    output logic            bus_we,
    output logic            bus_re,
    input  logic [DW-1:0]   bus_rdata,
    input  logic            bus_ready
);
    localparam int SW = DW/8;
    // Terminal count: ACCESS cycle index at which a missing READY ends the access.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } req_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    state_t     state, state_nxt;
    logic       gnt, gnt_nxt, last_gnt;
    logic       grant_en, acc_ok, acc_to;
    logic       we_q;
    logic [7:0] cnt;
    rsp_t       rsp;
    req_t       h0_r, h1_r, sel;

    assign h0_r = '{we: h0_we, addr: h0_addr, wdata: h0_wdata, wstrb: h0_wstrb};
    assign h1_r = '{we: h1_we, addr: h1_addr, wdata: h1_wdata, wstrb: h1_wstrb};
    assign sel  = gnt_nxt ? h1_r : h0_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, grant decision and qualified strobes / host responses
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        grant_en  = 1'b0;
        acc_ok    = 1'b0;
        acc_to    = 1'b0;
        case (state)
            IDLE: begin
                if (h0_req || h1_req) begin
                    grant_en  = 1'b1;
                    state_nxt = ACCESS;
                    // On a tie the host that did not win last time goes first.
                    gnt_nxt   = (h0_req && h1_req) ? ~last_gnt : h1_req;
                end
            end
            ACCESS: begin
                if (bus_ready) begin
                    acc_ok    = 1'b1;
                    state_nxt = RESP;
                end else if (cnt == TO_LAST) begin
                    acc_to    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        bus_we   = (state == ACCESS) &&  we_q;
        bus_re   = (state == ACCESS) && !we_q;
        h0_done  = (state == RESP) && !gnt;
        h1_done  = (state == RESP) &&  gnt;
        h0_rdata = h0_done ? rsp.rdata : '0;
        h1_rdata = h1_done ? rsp.rdata : '0;
        h0_err   = h0_done && rsp.err;
        h1_err   = h1_done && rsp.err;
    end

    // Request latch on grant, wait counter and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt       <= 1'b0;
            last_gnt  <= 1'b1;
            we_q      <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
            cnt       <= '0;
            rsp       <= '0;
        end else begin
            if (grant_en) begin
                gnt       <= gnt_nxt;
                last_gnt  <= gnt_nxt;
                we_q      <= sel.we;
                bus_addr  <= sel.addr;
                bus_wdata <= sel.wdata;
                bus_wstrb <= sel.wstrb;
                cnt       <= '0;
            end
            if (state == ACCESS) begin
                if (acc_ok) begin
                    rsp.rdata <= we_q ? '0 : bus_rdata;
                    rsp.err   <= 1'b0;
                end else if (acc_to) begin
                    rsp.rdata <= '0;
                    rsp.err   <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

endmodule
